btn_evt: RTL and testbench
==========================

BTN_EVT -- requirements
Module: btn_evt

Interface
REQ-001 SHALL have parameter LONG_CYCLES, default 24000000, hold length in clk cycles that classifies a press as long (2 s at 12 MHz).
REQ-002 SHALL have parameter GAP_CYCLES, default 3000000, release window in clk cycles for a second press to form a double (250 ms).
REQ-003 SHALL have parameter CNT_W, default 32, width of the internal counter.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port press  input  1  one-cycle pulse from the debouncer marking a new debounced press.
REQ-007 SHALL have port held  input  1  debounced button level, 1 while pressed.
REQ-008 SHALL have port short_evt  output  1  one-cycle pulse for a single short press.
REQ-009 SHALL have port long_evt  output  1  one-cycle pulse for a long press.
REQ-010 SHALL have port double_evt  output  1  one-cycle pulse for a double press.
REQ-011 SHALL have port led  output  4  bit0/1/2 toggle on short/long/double event, bit3 = busy (state not IDLE).

Function
REQ-012 SHALL implement an FSM with states IDLE, HELD1, LONG_REL, GAP, HELD2.
REQ-013 SHALL, in IDLE with press=1 at an edge, move to HELD1 with counter cleared to 0.
REQ-014 SHALL, in HELD1, increment counter each cycle while held=1.
REQ-015 SHALL, in HELD1 with held=1 and counter==LONG_CYCLES-1, move to LONG_REL and assert long_evt in the next cycle.
REQ-016 SHALL, in HELD1 with held=0, move to GAP with counter cleared; held=0 takes priority over the long threshold in the same cycle.
REQ-017 SHALL, in LONG_REL, ignore press and return to IDLE on the first cycle held=0; no short/double event results.
REQ-018 SHALL, in GAP, increment counter each cycle; press=1 moves to HELD2.
REQ-019 SHALL, in GAP with press=0 and counter==GAP_CYCLES-1, return to IDLE and assert short_evt in the next cycle; press on that same cycle wins (goes to HELD2, no short_evt).
REQ-020 SHALL, in HELD2, ignore press and hold length; on first cycle held=0 return to IDLE and assert double_evt in the next cycle.
REQ-021 SHALL ignore press in every state except IDLE and GAP.
REQ-022 SHALL clear the counter on every state transition and hold it at 0 in IDLE, LONG_REL, HELD2.
REQ-023 SHALL register all outputs; at most one of short_evt/long_evt/double_evt is high in any cycle, each for exactly one cycle per event.
REQ-024 SHALL toggle the matching led bit in the same cycle its event pulse is high.
REQ-025 SHALL treat a reset-illegal FSM encoding as IDLE on the next edge.
REQ-026 SHALL require LONG_CYCLES>=2 and GAP_CYCLES>=2, both < 2**CNT_W.

Reset
REQ-027 SHALL, while rst=1, immediately force state IDLE, counter 0, short_evt=long_evt=double_evt=0, led=4'b0000, regardless of clk.
REQ-028 SHALL, on rst asserted mid-sequence (any state), discard the pending classification; no event pulse follows reset release.
REQ-029 SHALL resume normal operation on the first clk edge after rst deasserts.

Verification (LONG_CYCLES=8, GAP_CYCLES=4)
REQ-030 Short: press pulse, held=1 for 3 cycles, then held=0, no press for 5 cycles -> one short_evt exactly 5 cycles after held falls, led=4'b0001, led[3]=0 afterwards.
REQ-031 Long: press pulse, held=1 for 12 cycles -> long_evt 9 cycles after the press edge, no further event on release, led=4'b0010.
REQ-032 Double: press, held 2 cycles, release 2 cycles, press, held 3 cycles, release -> one double_evt the cycle after second release, no short_evt, led=4'b0100.
REQ-033 Boundary: press on the exact GAP timeout cycle -> HELD2, double_evt on release, no short_evt; held falling on the long-threshold cycle -> GAP, no long_evt.
REQ-034 Reset: assert rst during GAP and during HELD1 (between clk edges) -> outputs 0 and led=0 immediately, no event after release; a fresh short press then classifies normally.
REQ-035 Ignored input: extra press pulses during HELD1, LONG_REL, HELD2 -> no change in classification or event count.

Source files
------------

// File: rtl/btn_evt.sv
// ---------------------------------------------------------------------------
// btn_evt -- classifies debounced button activity into short, long and
// double press events.
//
// A press that is held for LONG_CYCLES becomes a long press. A press that is
// released earlier opens a GAP_CYCLES window: a second press inside the
// window makes a double press, otherwise the window expiring makes a short
// press. Each event is a registered one-cycle pulse and toggles its led bit.
//
// Ports
//   clk        : single clock, rising edge active
//   rst        : asynchronous, active-high reset
//   press      : one-cycle pulse from the debouncer, new debounced press
//   held       : debounced button level, 1 while pressed
//   short_evt  : one-cycle pulse, single short press
//   long_evt   : one-cycle pulse, long press
//   double_evt : one-cycle pulse, double press
//   led[3:0]   : bit0/1/2 toggle on short/long/double, bit3 = busy
// ---------------------------------------------------------------------------
module btn_evt #(
  parameter int LONG_CYCLES = 24000000,
  parameter int GAP_CYCLES  = 3000000,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       press,
  input  logic       held,
  output logic       short_evt,
  output logic       long_evt,
  output logic       double_evt,
  output logic [3:0] led
);

  // Reject parameter sets the counter cannot represent or that would make
  // the terminal count underflow.
  if (LONG_CYCLES < 2 || GAP_CYCLES < 2 ||
      (LONG_CYCLES >> CNT_W) != 0 || (GAP_CYCLES >> CNT_W) != 0) begin : g_bad_params
    $error("btn_evt: LONG_CYCLES/GAP_CYCLES must be >= 2 and < 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HELD1    = 3'd1,
    LONG_REL = 3'd2,
    GAP      = 3'd3,
    HELD2    = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             short_nx;
  logic             long_nx;
  logic             double_nx;

  // State and counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state and counter logic. The counter defaults to 0, so every
  // transition and every non-timing state clears it; it only advances while
  // staying in HELD1 (still held, threshold not reached) or GAP.
  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    case (state)
      IDLE: begin
        if (press) state_nx = HELD1;
      end
      HELD1: begin
        // Release wins over reaching the long threshold in the same cycle.
        if (!held)                  state_nx = GAP;
        else if (cnt == LONG_LAST)  state_nx = LONG_REL;
        else                        cnt_nx   = cnt + CNT_ONE;
      end
      LONG_REL: begin
        if (!held) state_nx = IDLE;
      end
      GAP: begin
        // A second press on the timeout cycle still forms a double.
        if (press)                 state_nx = HELD2;
        else if (cnt == GAP_LAST)  state_nx = IDLE;
        else                       cnt_nx   = cnt + CNT_ONE;
      end
      HELD2: begin
        if (!held) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Event decode: each event corresponds to exactly one transition, so at
  // most one of these can be high and none can repeat on the next cycle.
  always_comb begin
    short_nx  = 1'b0;
    long_nx   = 1'b0;
    double_nx = 1'b0;
    case (state)
      HELD1:   long_nx   = held && (cnt == LONG_LAST);
      GAP:     short_nx  = !press && (cnt == GAP_LAST);
      HELD2:   double_nx = !held;
      default: ;
    endcase
  end

  // Registered outputs; led bits toggle on the same edge that raises the
  // matching pulse, and the busy bit mirrors the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      short_evt  <= 1'b0;
      long_evt   <= 1'b0;
      double_evt <= 1'b0;
      led        <= 4'b0000;
    end else begin
      short_evt  <= short_nx;
      long_evt   <= long_nx;
      double_evt <= double_nx;
      led[0]     <= led[0] ^ short_nx;
      led[1]     <= led[1] ^ long_nx;
      led[2]     <= led[2] ^ double_nx;
      led[3]     <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_btn_evt.sv
// ---------------------------------------------------------------------------
// tb_btn_evt -- directed self-checking bench for btn_evt with LONG_CYCLES=8,
// GAP_CYCLES=4. Inputs change 1 ns after a rising edge; outputs are read
// there too, so each tick() shows the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_btn_evt;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       press = 1'b0;
  logic       held = 1'b0;
  logic       short_evt;
  logic       long_evt;
  logic       double_evt;
  logic [3:0] led;

  int tests = 0;
  int fails = 0;

  // Event tallies, written only by the monitor below.
  int n_short  = 0;
  int n_long   = 0;
  int n_double = 0;
  int n_multi  = 0;

  btn_evt #(.LONG_CYCLES(8), .GAP_CYCLES(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .press      (press),
    .held       (held),
    .short_evt  (short_evt),
    .long_evt   (long_evt),
    .double_evt (double_evt),
    .led        (led)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    n_short  = n_short  + int'(short_evt);
    n_long   = n_long   + int'(long_evt);
    n_double = n_double + int'(double_evt);
    if (int'(short_evt) + int'(long_evt) + int'(double_evt) > 1) n_multi = n_multi + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    press = 1'b0;
    held  = 1'b0;
    rst   = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset_state();
    #1 rst = 1'b1;
    #1;
    tests++; if ({short_evt, long_evt, double_evt} !== 3'b000) begin fails++; $display("FAIL reset_evts: got %b want 000", {short_evt, long_evt, double_evt}); end
    tests++; if (led !== 4'b0000) begin fails++; $display("FAIL reset_led: got %b want 0000", led); end
    tick();
    rst = 1'b0;
    tick();
    tests++; if (led !== 4'b0000) begin fails++; $display("FAIL idle_led: got %b want 0000", led); end
  endtask

  task automatic test_short();
    int s0, l0, d0, m0;
    do_reset();
    s0 = n_short; l0 = n_long; d0 = n_double; m0 = n_multi;
    press = 1'b1; held = 1'b1;
    tick();                               // E0 -> HELD1
    press = 1'b0;
    tests++; if (led !== 4'b1000) begin fails++; $display("FAIL short_busy: got %b want 1000", led); end
    ticks(3);                             // E1..E3 held
    held = 1'b0;
    ticks(4);                             // E4 -> GAP, E5..E7 counting
    tests++; if (short_evt !== 1'b0) begin fails++; $display("FAIL short_early: got %b want 0", short_evt); end
    tick();                               // E8: timeout
    tests++; if (short_evt !== 1'b1) begin fails++; $display("FAIL short_pulse: got %b want 1", short_evt); end
    tests++; if (led !== 4'b0001) begin fails++; $display("FAIL short_led_on_pulse: got %b want 0001", led); end
    tick();
    tests++; if (short_evt !== 1'b0) begin fails++; $display("FAIL short_one_cycle: got %b want 0", short_evt); end
    ticks(3);
    tests++; if (led !== 4'b0001) begin fails++; $display("FAIL short_led: got %b want 0001", led); end
    tests++; if ({n_short - s0, n_long - l0, n_double - d0, n_multi - m0} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
      fails++; $display("FAIL short_counts: got s%0d l%0d d%0d m%0d want s1 l0 d0 m0", n_short - s0, n_long - l0, n_double - d0, n_multi - m0); end
  endtask

  task automatic test_long();
    int s0, l0, d0;
    do_reset();
    s0 = n_short; l0 = n_long; d0 = n_double;
    press = 1'b1; held = 1'b1;
    tick();                               // E0 -> HELD1
    press = 1'b0;
    ticks(2);                             // E1,E2
    press = 1'b1;                         // ignored in HELD1
    tick();                               // E3
    press = 1'b0;
    ticks(4);                             // E4..E7
    tests++; if (long_evt !== 1'b0) begin fails++; $display("FAIL long_early: got %b want 0", long_evt); end
    tick();                               // E8: threshold -> LONG_REL
    tests++; if (long_evt !== 1'b1) begin fails++; $display("FAIL long_pulse: got %b want 1", long_evt); end
    tests++; if (led !== 4'b1010) begin fails++; $display("FAIL long_led_busy: got %b want 1010", led); end
    press = 1'b1;                         // ignored in LONG_REL
    tick();                               // E9
    press = 1'b0;
    tests++; if (long_evt !== 1'b0) begin fails++; $display("FAIL long_one_cycle: got %b want 0", long_evt); end
    ticks(2);                             // E10,E11 still held
    held = 1'b0;
    ticks(8);
    tests++; if (led !== 4'b0010) begin fails++; $display("FAIL long_led: got %b want 0010", led); end
    tests++; if ({n_short - s0, n_long - l0, n_double - d0} !== {32'd0, 32'd1, 32'd0}) begin
      fails++; $display("FAIL long_counts: got s%0d l%0d d%0d want s0 l1 d0", n_short - s0, n_long - l0, n_double - d0); end
  endtask

  task automatic test_double();
    int s0, l0, d0;
    do_reset();
    s0 = n_short; l0 = n_long; d0 = n_double;
    press = 1'b1; held = 1'b1;
    tick();                               // E0 -> HELD1
    press = 1'b0;
    ticks(2);                             // E1,E2
    held = 1'b0;
    ticks(2);                             // E3 -> GAP, E4
    press = 1'b1; held = 1'b1;
    tick();                               // E5 -> HELD2
    press = 1'b0;
    tick();                               // E6
    press = 1'b1;                         // ignored in HELD2
    tick();                               // E7
    press = 1'b0;
    tick();                               // E8
    held = 1'b0;
    tests++; if (double_evt !== 1'b0) begin fails++; $display("FAIL double_early: got %b want 0", double_evt); end
    tick();                               // E9 -> IDLE
    tests++; if (double_evt !== 1'b1) begin fails++; $display("FAIL double_pulse: got %b want 1", double_evt); end
    tick();
    tests++; if (double_evt !== 1'b0) begin fails++; $display("FAIL double_one_cycle: got %b want 0", double_evt); end
    ticks(6);
    tests++; if (led !== 4'b0100) begin fails++; $display("FAIL double_led: got %b want 0100", led); end
    tests++; if ({n_short - s0, n_long - l0, n_double - d0} !== {32'd0, 32'd0, 32'd1}) begin
      fails++; $display("FAIL double_counts: got s%0d l%0d d%0d want s0 l0 d1", n_short - s0, n_long - l0, n_double - d0); end
  endtask

  task automatic test_boundary_gap();
    int s0, d0;
    do_reset();
    s0 = n_short; d0 = n_double;
    press = 1'b1; held = 1'b1;
    tick();                               // E0 -> HELD1
    press = 1'b0;
    tick();                               // E1
    held = 1'b0;
    ticks(4);                             // E2 -> GAP, E3..E5 count to 3
    press = 1'b1; held = 1'b1;
    tick();                               // E6: timeout cycle, press wins
    press = 1'b0;
    tests++; if (short_evt !== 1'b0 || led[3] !== 1'b1) begin fails++; $display("FAIL gap_edge_press: got short=%b busy=%b want short=0 busy=1", short_evt, led[3]); end
    tick();
    held = 1'b0;
    tick();
    tests++; if (double_evt !== 1'b1) begin fails++; $display("FAIL gap_edge_double: got %b want 1", double_evt); end
    ticks(6);
    tests++; if ({n_short - s0, n_double - d0} !== {32'd0, 32'd1}) begin
      fails++; $display("FAIL gap_edge_counts: got s%0d d%0d want s0 d1", n_short - s0, n_double - d0); end
  endtask

  task automatic test_boundary_long();
    int s0, l0;
    do_reset();
    s0 = n_short; l0 = n_long;
    press = 1'b1; held = 1'b1;
    tick();                               // E0 -> HELD1
    press = 1'b0;
    ticks(7);                             // E1..E7, counter reaches 7
    held = 1'b0;
    tick();                               // E8: release on threshold -> GAP
    tests++; if (long_evt !== 1'b0 || led[3] !== 1'b1) begin fails++; $display("FAIL long_edge_release: got long=%b busy=%b want long=0 busy=1", long_evt, led[3]); end
    ticks(3);                             // E9..E11
    tests++; if (short_evt !== 1'b0) begin fails++; $display("FAIL long_edge_short_early: got %b want 0", short_evt); end
    tick();                               // E12: gap timeout
    tests++; if (short_evt !== 1'b1) begin fails++; $display("FAIL long_edge_short: got %b want 1", short_evt); end
    tick();
    tests++; if (led !== 4'b0001) begin fails++; $display("FAIL long_edge_led: got %b want 0001", led); end
    tests++; if ({n_short - s0, n_long - l0} !== {32'd1, 32'd0}) begin
      fails++; $display("FAIL long_edge_counts: got s%0d l%0d want s1 l0", n_short - s0, n_long - l0); end
  endtask

  task automatic test_reset_midflight();
    int s0, l0, d0;
    do_reset();
    // Reset during GAP
    press = 1'b1; held = 1'b1;
    tick();
    press = 1'b0;
    tick();
    held = 1'b0;
    ticks(2);                             // in GAP
    #3 rst = 1'b1;
    #1;
    tests++; if (led !== 4'b0000 || {short_evt, long_evt, double_evt} !== 3'b000) begin
      fails++; $display("FAIL rst_gap_async: got led=%b evts=%b want 0000 000", led, {short_evt, long_evt, double_evt}); end
    tick();
    rst = 1'b0;
    s0 = n_short; l0 = n_long; d0 = n_double;
    ticks(12);
    tests++; if ({n_short - s0, n_long - l0, n_double - d0} !== {32'd0, 32'd0, 32'd0} || led !== 4'b0000) begin
      fails++; $display("FAIL rst_gap_after: got s%0d l%0d d%0d led=%b want none 0000", n_short - s0, n_long - l0, n_double - d0, led); end
    // Reset during HELD1, with led already non-zero from a short press
    press = 1'b1; held = 1'b1;
    tick();
    press = 1'b0;
    held = 1'b0;
    ticks(6);                             // short completes, led=0001
    press = 1'b1; held = 1'b1;
    tick();                               // HELD1
    press = 1'b0;
    tick();
    #4 rst = 1'b1;
    #1;
    tests++; if (led !== 4'b0000) begin fails++; $display("FAIL rst_held1_async: got led=%b want 0000", led); end
    tick();
    rst = 1'b0;
    held = 1'b0;
    s0 = n_short; l0 = n_long; d0 = n_double;
    ticks(12);
    tests++; if ({n_short - s0, n_long - l0, n_double - d0} !== {32'd0, 32'd0, 32'd0}) begin
      fails++; $display("FAIL rst_held1_after: got s%0d l%0d d%0d want none", n_short - s0, n_long - l0, n_double - d0); end
    // Fresh short press after reset
    press = 1'b1; held = 1'b1;
    tick();
    press = 1'b0;
    tick();
    held = 1'b0;
    ticks(5);                             // -> GAP then 4-cycle timeout
    tests++; if (short_evt !== 1'b1 || led !== 4'b0001) begin
      fails++; $display("FAIL rst_fresh_short: got short=%b led=%b want 1 0001", short_evt, led); end
  endtask

  initial begin
    test_reset_state();
    test_short();
    test_long();
    test_double();
    test_boundary_gap();
    test_boundary_long();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
